// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one single-port memory between IF (fetch) and
//                    MEM (load/store), one transaction at a time.
// Revision 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX  = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  // fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_dmtype,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  // hazard unit
  output logic        stall_if,
  output logic        stall_mem,
  // memory side
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_dmtype,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [3:0] C_STARVE_MAX   = 4'(STARVE_MAX);
  localparam logic [7:0] C_TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);
  localparam logic       C_OWN_IF       = 1'b0;
  localparam logic       C_OWN_D        = 1'b1;

  state_t      state_q,      state_d;
  logic        owner_q,      owner_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [7:0]  tmo_cnt_q,    tmo_cnt_d;
  logic        mem_en_q,     mem_en_d;
  logic        mem_we_q,     mem_we_d;
  logic [31:0] mem_addr_q,   mem_addr_d;
  logic [31:0] mem_wdata_q,  mem_wdata_d;
  logic [2:0]  mem_dmtype_q, mem_dmtype_d;
  logic        if_ack_q,     if_ack_d;
  logic        if_err_q,     if_err_d;
  logic [31:0] if_rdata_q,   if_rdata_d;
  logic        d_ack_q,      d_ack_d;
  logic        d_err_q,      d_err_d;
  logic [31:0] d_rdata_q,    d_rdata_d;

  logic        fetch_win;

  // Data has priority unless fetch has been passed over STARVE_MAX times.
  assign fetch_win = if_req & ((starve_cnt_q == C_STARVE_MAX) | ~d_req);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_dmtype_d = mem_dmtype_q;
    if_ack_d     = 1'b0;
    if_err_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_ack_d      = 1'b0;
    d_err_d      = 1'b0;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (!if_req) begin
          starve_cnt_d = 4'd0;
        end
        if (fetch_win) begin
          starve_cnt_d = 4'd0;
          owner_d      = C_OWN_IF;
          tmo_cnt_d    = 8'd0;
          mem_en_d     = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_wdata_d  = 32'h0;
          mem_dmtype_d = 3'b000;
          state_d      = S_WAIT;
        end else if (d_req) begin
          if (if_req && (starve_cnt_q != C_STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
          owner_d      = C_OWN_D;
          tmo_cnt_d    = 8'd0;
          mem_en_d     = 1'b1;
          mem_we_d     = d_we;
          mem_addr_d   = d_addr;
          mem_wdata_d  = d_wdata;
          mem_dmtype_d = d_dmtype;
          state_d      = S_WAIT;
        end
      end

      S_WAIT: begin
        tmo_cnt_d = tmo_cnt_q + 8'd1;
        // A response landing on the last counted cycle still completes cleanly.
        if (mem_rvalid) begin
          if (owner_q == C_OWN_D) begin
            d_rdata_d = mem_rdata;
            d_ack_d   = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_ack_d   = 1'b1;
          end
          state_d = S_ACK;
        end else if (tmo_cnt_q == C_TIMEOUT_LAST) begin
          if (owner_q == C_OWN_D) begin
            d_rdata_d = 32'h0;
            d_err_d   = 1'b1;
            d_ack_d   = 1'b1;
          end else begin
            if_rdata_d = 32'h0;
            if_err_d   = 1'b1;
            if_ack_d   = 1'b1;
          end
          state_d = S_ACK;
        end
      end

      S_ACK: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= C_OWN_IF;
      starve_cnt_q <= 4'd0;
      tmo_cnt_q    <= 8'd0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_dmtype_q <= 3'b000;
      if_ack_q     <= 1'b0;
      if_err_q     <= 1'b0;
      if_rdata_q   <= 32'h0;
      d_ack_q      <= 1'b0;
      d_err_q      <= 1'b0;
      d_rdata_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_dmtype_q <= mem_dmtype_d;
      if_ack_q     <= if_ack_d;
      if_err_q     <= if_err_d;
      if_rdata_q   <= if_rdata_d;
      d_ack_q      <= d_ack_d;
      d_err_q      <= d_err_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign if_ack     = if_ack_q;
  assign if_err     = if_err_q;
  assign if_rdata   = if_rdata_q;
  assign d_ack      = d_ack_q;
  assign d_err      = d_err_q;
  assign d_rdata    = d_rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_dmtype = mem_dmtype_q;
  assign stall_if   = if_req & ~if_ack_q;
  assign stall_mem  = d_req & ~d_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : directed self-checking bench for mem_port_arbiter.
// Revision 1.0
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_dmtype;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        stall_if;
  logic        stall_mem;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_dmtype;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_pass;
  int n_total;

  mem_port_arbiter #(
    .STARVE_MAX (4),
    .TIMEOUT_CYC(64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_dmtype  (d_dmtype),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_dmtype(mem_dmtype),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    d_dmtype = 0; mem_rvalid = 0; mem_rdata = 0;
    rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({if_ack, d_ack, if_err, d_err, mem_en, mem_we, stall_if, stall_mem} !== 8'h00)
      $display("FAIL reset_ctrl: got %b want 00000000",
               {if_ack, d_ack, if_err, d_err, mem_en, mem_we, stall_if, stall_mem});
    else n_pass++;
    n_total++;
    if ({mem_addr, mem_wdata, if_rdata, d_rdata, mem_dmtype} !== 131'h0)
      $display("FAIL reset_data: addr %h wdata %h if_rdata %h d_rdata %h dmtype %b want all 0",
               mem_addr, mem_wdata, if_rdata, d_rdata, mem_dmtype);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    bit saw_ack;
    do_reset();
    d_req = 1; d_we = 0; d_addr = 32'h200; d_dmtype = 3'b010;
    tick();
    n_total++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h200)
      $display("FAIL rstwait_grant: mem_en %b addr %h want 1 00000200", mem_en, mem_addr);
    else n_pass++;
    tick(); tick();
    rst = 1;
    tick();
    rst = 0; d_req = 0; mem_rvalid = 1; mem_rdata = 32'hAAAA_5555;
    n_total++;
    if (dut.state_q !== 2'd0 || d_ack !== 1'b0 || mem_en !== 1'b0 || mem_addr !== 32'h0)
      $display("FAIL rstwait_state: state %0d d_ack %b mem_en %b addr %h want 0 0 0 0",
               dut.state_q, d_ack, mem_en, mem_addr);
    else n_pass++;
    saw_ack = 0;
    tick();
    mem_rvalid = 0;
    for (int i = 0; i < 4; i++) begin
      if (d_ack === 1'b1 || if_ack === 1'b1) saw_ack = 1;
      tick();
    end
    n_total++;
    if (saw_ack !== 1'b0 || d_rdata !== 32'h0 || dut.state_q !== 2'd0)
      $display("FAIL rstwait_stale: ack_seen %b d_rdata %h state %0d want 0 0 0",
               saw_ack, d_rdata, dut.state_q);
    else n_pass++;
  endtask

  task automatic test_single_fetch();
    do_reset();
    if_req = 1; if_addr = 32'h0000_0010;
    #1;
    n_total++;
    if (stall_if !== 1'b1) $display("FAIL fetch_stall0: got %b want 1", stall_if);
    else n_pass++;
    tick();
    n_total++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h10 || mem_dmtype !== 3'b000 || mem_we !== 1'b0)
      $display("FAIL fetch_cmd: en %b addr %h dmtype %b we %b want 1 00000010 000 0",
               mem_en, mem_addr, mem_dmtype, mem_we);
    else n_pass++;
    tick();
    n_total++;
    if (mem_en !== 1'b0 || if_ack !== 1'b0 || stall_if !== 1'b1)
      $display("FAIL fetch_wait: en %b ack %b stall %b want 0 0 1", mem_en, if_ack, stall_if);
    else n_pass++;
    mem_rvalid = 1; mem_rdata = 32'h0040_0093;
    tick();
    n_total++;
    if (if_ack !== 1'b1 || if_rdata !== 32'h0040_0093 || if_err !== 1'b0 || stall_if !== 1'b0)
      $display("FAIL fetch_ack: ack %b rdata %h err %b stall %b want 1 00400093 0 0",
               if_ack, if_rdata, if_err, stall_if);
    else n_pass++;
    mem_rvalid = 0; if_req = 0;
    tick();
    n_total++;
    if (if_ack !== 1'b0 || if_rdata !== 32'h0040_0093)
      $display("FAIL fetch_hold: ack %b rdata %h want 0 00400093", if_ack, if_rdata);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    if_req = 1; if_addr = 32'h20;
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_dmtype = 3'b001;
    tick();
    n_total++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 ||
        mem_wdata !== 32'hDEAD_BEEF || mem_dmtype !== 3'b001 || stall_mem !== 1'b1)
      $display("FAIL simul_data_cmd: en %b we %b addr %h wdata %h dmtype %b stall %b want 1 1 00000100 deadbeef 001 1",
               mem_en, mem_we, mem_addr, mem_wdata, mem_dmtype, stall_mem);
    else n_pass++;
    mem_rvalid = 1; mem_rdata = 32'h0;
    tick();
    n_total++;
    if (d_ack !== 1'b1 || if_ack !== 1'b0 || d_err !== 1'b0 || stall_mem !== 1'b0)
      $display("FAIL simul_d_ack: d_ack %b if_ack %b d_err %b stall_mem %b want 1 0 0 0",
               d_ack, if_ack, d_err, stall_mem);
    else n_pass++;
    mem_rvalid = 0; d_req = 0;
    tick();
    tick();
    n_total++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h20 || mem_we !== 1'b0 || mem_dmtype !== 3'b000)
      $display("FAIL simul_fetch_cmd: en %b addr %h we %b dmtype %b want 1 00000020 0 000",
               mem_en, mem_addr, mem_we, mem_dmtype);
    else n_pass++;
    mem_rvalid = 1; mem_rdata = 32'h13;
    tick();
    n_total++;
    if (if_ack !== 1'b1 || if_rdata !== 32'h13)
      $display("FAIL simul_if_ack: ack %b rdata %h want 1 00000013", if_ack, if_rdata);
    else n_pass++;
    mem_rvalid = 0; if_req = 0;
    tick();
  endtask

  task automatic test_starvation();
    int  data_grants;
    bit  got_fetch;
    int  guard;
    do_reset();
    if_req = 1; if_addr = 32'h40;
    d_req = 1; d_we = 0; d_addr = 32'h300; d_dmtype = 3'b010;
    data_grants = 0;
    got_fetch = 0;
    for (int g = 0; g < 7 && !got_fetch; g++) begin
      guard = 0;
      while (mem_en !== 1'b1 && guard < 10) begin
        tick();
        guard++;
      end
      if (mem_en !== 1'b1) begin
        n_total++;
        $display("FAIL starve_grant_timeout: mem_en %b want 1 within 10 cycles", mem_en);
        break;
      end
      if (mem_addr === 32'h40) begin
        got_fetch = 1;
        n_total++;
        if (dut.starve_cnt_q !== 4'd0)
          $display("FAIL starve_cnt_clear: got %0d want 0", dut.starve_cnt_q);
        else n_pass++;
      end else begin
        data_grants++;
      end
      mem_rvalid = 1; mem_rdata = 32'(g);
      tick();
      mem_rvalid = 0;
      if (got_fetch) begin
        n_total++;
        if (if_ack !== 1'b1) $display("FAIL starve_if_ack: got %b want 1", if_ack);
        else n_pass++;
        if_req = 0; d_req = 0;
      end
      tick();
    end
    if_req = 0; d_req = 0;
    n_total++;
    if (data_grants !== 4 || got_fetch !== 1'b1)
      $display("FAIL starve_count: data grants %0d fetch %b want 4 1", data_grants, got_fetch);
    else n_pass++;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    d_req = 1; d_we = 0; d_addr = 32'h400; d_dmtype = 3'b000;
    tick();
    mem_rvalid = 1; mem_rdata = 32'hCAFE_0001;
    tick();
    mem_rvalid = 0;
    n_total++;
    if (d_ack !== 1'b1 || d_rdata !== 32'hCAFE_0001)
      $display("FAIL tmo_preload: ack %b rdata %h want 1 cafe0001", d_ack, d_rdata);
    else n_pass++;
    tick();
    tick();
    n = 0;
    while (d_ack !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    n_total++;
    if (n !== 64 || d_err !== 1'b1 || d_rdata !== 32'h0)
      $display("FAIL tmo_ack: cycles %0d err %b rdata %h want 64 1 00000000", n, d_err, d_rdata);
    else n_pass++;
    d_req = 0;
    tick();
    n_total++;
    if (d_ack !== 1'b0 || d_err !== 1'b0)
      $display("FAIL tmo_deassert: ack %b err %b want 0 0", d_ack, d_err);
    else n_pass++;
    mem_rvalid = 1; mem_rdata = 32'h55;
    tick();
    mem_rvalid = 0;
    tick();
    n_total++;
    if (d_ack !== 1'b0 || d_rdata !== 32'h0 || dut.state_q !== 2'd0)
      $display("FAIL tmo_late_rvalid: ack %b rdata %h state %0d want 0 00000000 0",
               d_ack, d_rdata, dut.state_q);
    else n_pass++;
  endtask

  task automatic test_collision();
    do_reset();
    if_req = 1; if_addr = 32'h80;
    tick();
    repeat (63) tick();
    n_total++;
    if (if_ack !== 1'b0 || dut.state_q !== 2'd1)
      $display("FAIL coll_pre: ack %b state %0d want 0 1", if_ack, dut.state_q);
    else n_pass++;
    mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    tick();
    mem_rvalid = 0;
    n_total++;
    if (if_ack !== 1'b1 || if_err !== 1'b0 || if_rdata !== 32'h1234_5678)
      $display("FAIL coll_ack: ack %b err %b rdata %h want 1 0 12345678", if_ack, if_err, if_rdata);
    else n_pass++;
    if_req = 0;
    tick();
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_reset_mid_wait();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_collision();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between two requesters of the 5-stage pipeline: the IF stage (instruction fetch) and the MEM stage (loads/stores).
- Issues one transaction at a time to memory and waits for that memory's variable-latency response. It returns data with a one-cycle ack pulse.
- Drives stall signals back to the pipeline hazard logic.
- Data port has fixed priority, with a starvation guard for fetch and a response timeout.

Parameters:
- STARVE_MAX, 4, consecutive data grants allowed while a fetch waits before fetch is forced to win (1..15).
- TIMEOUT_CYC, 64, cycles in WAIT without mem_rvalid before the transaction is aborted with an error (2..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_ack.
- if_addr  in  32  fetch address, word-aligned.
- if_ack  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  32  fetched instruction; holds last value.
- d_req  in  1  data request; held with d_* stable until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_dmtype  in  3  access width/sign code, passed through to memory unchanged.
- d_ack  out  1  one-cycle pulse: d_rdata valid / store done.
- d_rdata  out  32  load data; holds last value.
- d_err  out  1  valid with d_ack: 1 = timed out.
- if_err  out  1  valid with if_ack: 1 = timed out.
- stall_if  out  1  if_req & ~if_ack (combinational).
- stall_mem  out  1  d_req & ~d_ack (combinational).
- mem_en  out  1  one-cycle command strobe.
- mem_we  out  1  write enable, valid with mem_en.
- mem_addr  out  32  address, valid with mem_en.
- mem_wdata  out  32  write data, valid with mem_en.
- mem_dmtype  out  3  dmtype for data transactions; 3'b000 (word) for fetch.
- mem_rvalid  in  1  memory completion pulse (reads and writes).
- mem_rdata  in  32  read data, valid with mem_rvalid.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; all acks, errs and mem_en = 0.
  - if_rdata, d_rdata, mem_addr, mem_wdata = 0; mem_we=0; mem_dmtype=0.
  - starve_cnt=0; timeout counter=0.
  - Reset mid-transaction abandons it: no ack is ever issued for it.
- States: IDLE, WAIT, ACK.
- IDLE:
  - No request: stay in IDLE.
  - Winner = fetch if if_req and (starve_cnt==STARVE_MAX or !d_req); otherwise data if d_req.
  - Grant cycle: register winner's command onto mem_*; mem_en=1 for exactly the next cycle only; latch owner; clear timeout counter; go to WAIT.
- starve_cnt:
  - Increment (saturating at STARVE_MAX) on a data grant while if_req=1.
  - Clear on a fetch grant, or when if_req=0 in IDLE.
- WAIT:
  - Timeout counter increments each cycle.
  - On mem_rvalid=1: owner's rdata register <= mem_rdata; owner's err <= 0; go to ACK.
  - Else if counter reaches TIMEOUT_CYC-1: owner's rdata <= 32'h0; owner's err <= 1; go to ACK.
  - mem_rvalid and timeout in the same cycle: rvalid wins, err=0.
- ACK:
  - Owner's ack=1 for this single cycle; no arbitration in this cycle, so the requester can drop or change req.
  - Next state IDLE.
  - ack and err deassert after this one cycle.
- mem_rvalid while in IDLE or ACK (stale/late response): ignored, no state change.
- Latency: request seen in IDLE at cycle T → mem_en at T+1. Memory answering k cycles after mem_en → ack at T+k+2.
- Max throughput: one transaction per (memory latency + 3) cycles.
- Requests that drop before ack are protocol violations. Once granted, the transaction completes regardless.
- Write transactions return d_rdata = mem_rdata; the pipeline ignores it.

Test Plan:
- Reset mid-WAIT: rst asserted 2 cycles after mem_en with d_req, then mem_rvalid pulses → no d_ack, state IDLE, all outputs 0.
- Single fetch: if_req=1, if_addr=0x0000_0010; memory answers 1 cycle after mem_en with 0x0040_0093 → mem_en with mem_addr=0x10, mem_dmtype=0; if_ack with if_rdata=0x0040_0093 exactly 3 cycles after req; stall_if high until then.
- Simultaneous req: if_req=d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF, d_dmtype=3'b001 → data granted first (mem_we=1, mem_dmtype=001), d_ack first, then the fetch is granted in the following IDLE.
- Starvation: if_req held high, d_req re-asserted every cycle after each d_ack, STARVE_MAX=4 → exactly 4 data grants, then fetch grant; starve_cnt back to 0.
- Timeout: d_req load, memory never responds, TIMEOUT_CYC=64 → d_ack with d_err=1 and d_rdata=0 at 64 cycles after WAIT entry; a mem_rvalid arriving afterwards is ignored.
- Rvalid/timeout collision: mem_rvalid on the final WAIT cycle with 0x1234_5678 → if_ack, if_err=0, if_rdata=0x1234_5678.
